// File: rtl/scroll_text_engine.sv
// Message scroller feeding the 4-digit 7-seg glyph decoder: host-loaded glyph RAM,
// 4-char window stepped once per prescaler period. Optional trailing blank gap: SCROLL_GAP_EN.
module scroll_text_engine #(
  parameter int unsigned          MSG_DEPTH  = 16,
  parameter int unsigned          CODE_W     = 4,
  parameter int unsigned          TICK_MAX   = 50000000,
  parameter logic [CODE_W-1:0]    BLANK_CODE = CODE_W'(2)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0]  wr_addr,
  input  logic [CODE_W-1:0]             wr_data,
  input  logic [$clog2(MSG_DEPTH):0]    msg_len,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          pause,
  output logic [CODE_W-1:0]             char3,
  output logic [CODE_W-1:0]             char2,
  output logic [CODE_W-1:0]             char1,
  output logic [CODE_W-1:0]             char0,
  output logic                          frame_valid,
  output logic                          busy
);

  localparam int unsigned AW = $clog2(MSG_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = AW + 2;
  localparam int unsigned CW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, SCROLL, PAUSED} state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   ram [MSG_DEPTH];
  logic [PW-1:0]       pos_q, pos_d;
  logic [CW-1:0]       presc_q, presc_d;
  logic [LW-1:0]       len_q, len_d, len_clamp;
  logic [PW-1:0]       seq_len_q, seq_len_d;
  logic                load, blank;
  logic [PW-1:0]       idx [4];
  logic [CODE_W-1:0]   win [4];

  // Length of the virtual sequence being scrolled (message plus optional blank gap)
  function automatic logic [PW-1:0] seq_len(input logic [LW-1:0] l);
`ifdef SCROLL_GAP_EN
    return PW'(l) + PW'(4);
`else
    return PW'(l);
`endif
  endfunction

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    presc_d   = presc_q;
    len_d     = len_q;
    load      = 1'b0;
    blank     = 1'b0;
    len_clamp = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
    seq_len_q = seq_len(len_q);
    if (stop) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        blank   = 1'b1;
      end
    end else if (start) begin
      if (len_clamp == '0) begin
        if (state_q != IDLE) begin
          state_d = IDLE;
          blank   = 1'b1;
        end
      end else begin
        state_d = SCROLL;
        pos_d   = '0;
        presc_d = '0;
        len_d   = len_clamp;
        load    = 1'b1;
      end
    end else if (state_q != IDLE) begin
      if (pause) begin
        state_d = PAUSED;
      end else begin
        state_d = SCROLL;
        if (presc_q == CW'(TICK_MAX)) begin
          presc_d = '0;
          pos_d   = (pos_q + PW'(1) == seq_len_q) ? '0 : pos_q + PW'(1);
          load    = 1'b1;
        end else begin
          presc_d = presc_q + CW'(1);
        end
      end
    end
  end

  // Window indices walk forward from the new position, wrapping without division
  always_comb begin
    seq_len_d = seq_len(len_d);
    idx[0]    = pos_d;
    for (int k = 1; k < 4; k++) begin
      idx[k] = (idx[k-1] + PW'(1) == seq_len_d) ? '0 : idx[k-1] + PW'(1);
    end
    for (int k = 0; k < 4; k++) begin
`ifdef SCROLL_GAP_EN
      win[k] = (idx[k] < PW'(len_d)) ? ram[idx[k][AW-1:0]] : BLANK_CODE;
`else
      win[k] = ram[idx[k][AW-1:0]];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      presc_q     <= '0;
      len_q       <= '0;
      char3       <= BLANK_CODE;
      char2       <= BLANK_CODE;
      char1       <= BLANK_CODE;
      char0       <= BLANK_CODE;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < int'(MSG_DEPTH); i++) ram[i] <= BLANK_CODE;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      presc_q     <= presc_d;
      len_q       <= len_d;
      frame_valid <= load | blank;
      busy        <= (state_d != IDLE);
      if (load) begin
        char3 <= win[0];
        char2 <= win[1];
        char1 <= win[2];
        char0 <= win[3];
      end else if (blank) begin
        char3 <= BLANK_CODE;
        char2 <= BLANK_CODE;
        char1 <= BLANK_CODE;
        char0 <= BLANK_CODE;
      end
      if (wr_en) ram[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_scroll_text_engine.sv
// Bench for scroll_text_engine: vector table, directed corner sequences and random
// traffic checked against a sequence-level reference model.
module tb_scroll_text_engine;

  localparam int TM    = 3;
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset, wr_en, start, stop, pause;
  logic [3:0] wr_addr, wr_data;
  logic [4:0] msg_len;
  logic [3:0] char3, char2, char1, char0;
  logic       frame_valid, busy;

  int n_cmp = 0;
  int n_err = 0;

  scroll_text_engine #(.MSG_DEPTH(DEPTH), .CODE_W(4), .TICK_MAX(TM), .BLANK_CODE(4'd2)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .stop(stop), .pause(pause),
    .char3(char3), .char2(char2), .char1(char1), .char0(char0),
    .frame_valid(frame_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference model: message array, active flag, position in virtual sequence, cycle count
  logic [3:0] m_ram [DEPTH];
  bit         m_act;
  int         m_len, m_pos, m_cnt;
  logic [3:0] m_ch [4];
  bit         m_fv;

  function automatic int m_seq_len();
`ifdef SCROLL_GAP_EN
    return m_len + 4;
`else
    return m_len;
`endif
  endfunction

  function automatic logic [3:0] m_sym(input int i);
    return (i < m_len) ? m_ram[i] : 4'd2;
  endfunction

  task automatic m_show();
    for (int k = 0; k < 4; k++) m_ch[k] = m_sym((m_pos + k) % m_seq_len());
  endtask

  task automatic m_blank();
    for (int k = 0; k < 4; k++) m_ch[k] = 4'd2;
  endtask

  task automatic m_update(input bit rst, we, input logic [3:0] wa, wd, input logic [4:0] ml,
                          input bit st, sp, pa);
    int l;
    m_fv = 1'b0;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_ram[i] = 4'd2;
      m_act = 0; m_len = 0; m_pos = 0; m_cnt = 0;
      m_blank();
      return;
    end
    if (sp) begin
      if (m_act) begin m_act = 0; m_blank(); m_fv = 1; end
    end else if (st) begin
      l = (int'(ml) > DEPTH) ? DEPTH : int'(ml);
      if (l == 0) begin
        if (m_act) begin m_act = 0; m_blank(); m_fv = 1; end
      end else begin
        m_act = 1; m_len = l; m_pos = 0; m_cnt = 0; m_show(); m_fv = 1;
      end
    end else if (m_act && !pa) begin
      if (m_cnt == TM) begin
        m_cnt = 0; m_pos = (m_pos + 1) % m_seq_len(); m_show(); m_fv = 1;
      end else begin
        m_cnt++;
      end
    end
    if (we) m_ram[wa] = wd;
  endtask

  function automatic logic [15:0] dut_chars();
    return {char3, char2, char1, char0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, we, input logic [3:0] wa, wd, input logic [4:0] ml,
                      input bit st, sp, pa);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd; msg_len = ml;
    start = st; stop = sp; pause = pa;
    @(posedge clock);
    m_update(rst, we, wa, wd, ml, st, sp, pa);
    #1;
    check("model", {14'd0, dut_chars(), frame_valid, busy},
          {14'd0, m_ch[0], m_ch[1], m_ch[2], m_ch[3], m_fv, m_act});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [3:0] a, d);
    step(0, 1, a, d, 0, 0, 0, 0);
  endtask

  task automatic load_msg();
    logic [3:0] msg [6];
    msg = '{4'd6, 4'd4, 4'd5, 4'd5, 4'd6, 4'd1};
    for (int i = 0; i < 6; i++) wr(4'(i), msg[i]);
  endtask

  typedef struct {
    bit rst, we; logic [3:0] wa, wd; logic [4:0] ml; bit st, sp, pa;
    logic [15:0] exp_ch; bit exp_fv, exp_busy;
  } vec_t;

  function automatic vec_t mk(input bit rst, we, input logic [3:0] wa, wd, input logic [4:0] ml,
                              input bit st, sp, input logic [15:0] ch, input bit fv, bsy);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.ml = ml; v.st = st; v.sp = sp; v.pa = 0;
    v.exp_ch = ch; v.exp_fv = fv; v.exp_busy = bsy;
    return v;
  endfunction

  vec_t tbl [18];
  int   n;
  bit   fv_seen;

  initial begin
    tbl[0]  = mk(1, 0, 0, 0,    0, 0, 0, 16'h2222, 0, 0);
    tbl[1]  = mk(0, 1, 0, 6,    0, 0, 0, 16'h2222, 0, 0);
    tbl[2]  = mk(0, 1, 1, 4,    0, 0, 0, 16'h2222, 0, 0);
    tbl[3]  = mk(0, 1, 2, 5,    0, 0, 0, 16'h2222, 0, 0);
    tbl[4]  = mk(0, 1, 3, 5,    0, 0, 0, 16'h2222, 0, 0);
    tbl[5]  = mk(0, 1, 4, 6,    0, 0, 0, 16'h2222, 0, 0);
    tbl[6]  = mk(0, 1, 5, 1,    0, 0, 0, 16'h2222, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 5'd6, 1, 0, 16'h6455, 1, 1);
    tbl[8]  = mk(0, 0, 0, 0,    0, 0, 0, 16'h6455, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0,    0, 0, 0, 16'h6455, 0, 1);
    tbl[10] = mk(0, 0, 0, 0,    0, 0, 0, 16'h6455, 0, 1);
    tbl[11] = mk(0, 0, 0, 0,    0, 0, 0, 16'h4556, 1, 1);
    tbl[12] = mk(0, 0, 0, 0,    0, 0, 0, 16'h4556, 0, 1);
    tbl[13] = mk(0, 0, 0, 0,    0, 0, 0, 16'h4556, 0, 1);
    tbl[14] = mk(0, 0, 0, 0,    0, 0, 0, 16'h4556, 0, 1);
    tbl[15] = mk(0, 0, 0, 0,    0, 0, 0, 16'h5561, 1, 1);
    tbl[16] = mk(0, 0, 0, 0,    0, 0, 1, 16'h2222, 1, 0);
    tbl[17] = mk(0, 0, 0, 0,    0, 0, 0, 16'h2222, 0, 0);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ml, tbl[i].st, tbl[i].sp, tbl[i].pa);
      check($sformatf("vec%0d", i), {15'd0, dut_chars(), frame_valid},
            {15'd0, tbl[i].exp_ch, tbl[i].exp_fv});
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
    end

    // Reset mid-scroll clears outputs and the message RAM
    step(0, 0, 0, 0, 5'd4, 1, 0, 0);
    idle(5);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_chars", 32'(dut_chars()), 32'h2222);
    check("rst_busy_fv", {30'd0, busy, frame_valid}, 32'd0);
    step(0, 0, 0, 0, 5'd4, 1, 0, 0);
    check("rst_ram_blank", {15'd0, dut_chars(), busy}, {15'd0, 16'h2222, 1'b1});
    step(0, 0, 0, 0, 0, 0, 1, 0);

    // Full wrap of a 6-char message
    load_msg();
    step(0, 0, 0, 0, 5'd6, 1, 0, 0);
    idle(6 * (TM + 1));
`ifdef SCROLL_GAP_EN
    idle(TM + 1);
    check("wrap_gap", 32'(dut_chars()), 32'h2226);
`else
    check("wrap", 32'(dut_chars()), 32'h6455);
`endif

    // Pause mid-period: frozen, then the remaining count completes
    step(0, 0, 0, 0, 5'd6, 1, 0, 0);
    idle(2);
    fv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1);
      fv_seen |= frame_valid;
    end
    check("pause_hold", {15'd0, dut_chars(), fv_seen}, {15'd0, 16'h6455, 1'b0});
    n = 1;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    while (!frame_valid && n <= 20) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    check("pause_resume_latency", 32'(n), 32'(TM - 2 + 1));
    check("pause_resume_chars", 32'(dut_chars()), 32'h4556);

    // start+stop together: stop wins; zero-length start stays idle
    step(0, 0, 0, 0, 5'd6, 1, 1, 0);
    check("startstop", {14'd0, dut_chars(), frame_valid, busy}, {14'd0, 16'h2222, 2'b10});
    step(0, 0, 0, 0, 5'd0, 1, 0, 0);
    check("len0", {14'd0, dut_chars(), frame_valid, busy}, {14'd0, 16'h2222, 2'b00});

    // Short message repeats; oversized length clamps to depth
    wr(0, 9);
    wr(1, 0);
    step(0, 0, 0, 0, 5'd2, 1, 0, 0);
`ifndef SCROLL_GAP_EN
    check("len2_a", 32'(dut_chars()), 32'h9090);
    idle(TM + 1);
    check("len2_b", 32'(dut_chars()), 32'h0909);
`endif
    for (int i = 0; i < DEPTH; i++) wr(4'(i), 4'(i));
    step(0, 0, 0, 0, 5'd20, 1, 0, 0);
    check("clamp_a", 32'(dut_chars()), 32'h0123);
    idle(15 * (TM + 1));
`ifndef SCROLL_GAP_EN
    check("clamp_b", 32'(dut_chars()), 32'hF012);
`endif

    // RAM write during scroll shows only at the next window update
    load_msg();
    step(0, 0, 0, 0, 5'd6, 1, 0, 0);
    idle(1);
    wr(1, 3);
    check("wr_hold", 32'(dut_chars()), 32'h6455);
    idle(1);
    check("wr_hold2", 32'(dut_chars()), 32'h6455);
    idle(1);
    check("wr_update", 32'(dut_chars()), 32'h3556);

    // Random traffic against the model
    pause = 0;
    for (int i = 0; i < 500; i++) begin
      bit p;
      p = ($urandom_range(0, 9) == 0) ? !pause : pause;
      step($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0, 4'($urandom), 4'($urandom),
           5'($urandom_range(0, 20)), $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
